reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises and debounces a raw reset pin, merges it with
// a software request and the block's own reset, holds every output for a
// minimum time, and then releases the channels one at a time, bit 0 first.
// `cause` records which source started the most recent reset.
//
// `ready` is a status level, not a handshake. It is high exactly while every
// channel is released, and nothing ever waits on it from the other side.
module reset_sequencer #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int STAGE_DELAY     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rawReset,
  input  logic                swResetReq,
  output logic [CHANNELS-1:0] resetOut,
  output logic                ready,
  output logic [1:0]          cause,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int STAGE_W = $clog2(STAGE_DELAY + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_DELAY - 1);

  localparam logic [1:0] CAUSE_POWER = 2'b00;
  localparam logic [1:0] CAUSE_PIN   = 2'b01;
  localparam logic [1:0] CAUSE_SW    = 2'b10;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   deb;
  logic [DEB_W-1:0]       deb_cnt;

  state_t                 state, state_n;
  logic [HOLD_W-1:0]      hold_cnt, hold_n;
  logic [STAGE_W-1:0]     stage_cnt, stage_n;
  logic [CHANNELS-1:0]    out_n;
  logic                   ready_n;
  logic [1:0]             cause_n;
  logic                   reenter;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign reenter   = deb | swResetReq;
  assign dbg_state = state;

  // Pin synchroniser; resets to "asserted" so the pin must prove it is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rawReset};
    end
  end

  // Debouncer: the level flips only after a full run of differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb     <= 1'b1;
      deb_cnt <= '0;
    end else if (sync_out != deb) begin
      if (deb_cnt >= DEB_LAST) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ASSERT;
      hold_cnt  <= '0;
      stage_cnt <= '0;
      resetOut  <= '1;
      ready     <= 1'b0;
      cause     <= CAUSE_POWER;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      stage_cnt <= stage_n;
      resetOut  <= out_n;
      ready     <= ready_n;
      cause     <= cause_n;
    end
  end

  // Next-state and next-output logic. Channels release by shifting zeros in
  // from bit 0, so cleared bits stay cleared and the order is fixed.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    stage_n = stage_cnt;
    out_n   = resetOut;
    ready_n = ready;
    cause_n = cause;

    case (state)
      ST_ASSERT: begin
        out_n   = '1;
        ready_n = 1'b0;
        stage_n = '0;
        if (hold_cnt != HOLD_MAX) begin
          hold_n = hold_cnt + 1'b1;
        end
        // The current edge completes the hold time when the count is at
        // HOLD_CYCLES-1, so release starts exactly HOLD_CYCLES after entry.
        if ((hold_cnt >= HOLD_LAST) && !deb && !swResetReq) begin
          state_n = ST_RELEASE;
          hold_n  = '0;
        end
      end

      ST_RELEASE: begin
        if (reenter) begin
          state_n = ST_ASSERT;
          out_n   = '1;
          ready_n = 1'b0;
          hold_n  = '0;
          stage_n = '0;
          cause_n = deb ? CAUSE_PIN : CAUSE_SW;
        end else if (stage_cnt >= STAGE_LAST) begin
          stage_n = '0;
          out_n   = resetOut << 1;
          if (out_n == '0) begin
            ready_n = 1'b1;
            state_n = ST_RUN;
          end
        end else begin
          stage_n = stage_cnt + 1'b1;
        end
      end

      ST_RUN: begin
        out_n   = '0;
        ready_n = 1'b1;
        if (reenter) begin
          state_n = ST_ASSERT;
          out_n   = '1;
          ready_n = 1'b0;
          hold_n  = '0;
          stage_n = '0;
          cause_n = deb ? CAUSE_PIN : CAUSE_SW;
        end
      end

      default: begin
        state_n = ST_ASSERT;
        out_n   = '1;
        ready_n = 1'b0;
        hold_n  = '0;
        stage_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: directed scenarios followed by random pin,
// software and reset activity. A timestamp-based reference model predicts the
// outputs after every clock edge and a monitor compares them on the falling
// edge.
module tb_reset_sequencer;

  localparam int CH   = 4;
  localparam int SYN  = 2;
  localparam int DEB  = 16;
  localparam int HOLD = 8;
  localparam int SD   = 4;
  localparam int W    = CH + 3;

  logic          clk;
  logic          reset;
  logic          rawReset;
  logic          swResetReq;
  logic [CH-1:0] resetOut;
  logic          ready;
  logic [1:0]    cause;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [W-1:0] exp_q[$];

  reset_sequencer #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SYN),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .STAGE_DELAY     (SD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rawReset   (rawReset),
    .swResetReq (swResetReq),
    .resetOut   (resetOut),
    .ready      (ready),
    .cause      (cause),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: remembers when ASSERT and RELEASE were entered and
  // derives each output bit from elapsed edges.
  bit         m_assert;
  bit         m_deb;
  int         m_run;
  int         m_a;
  int         m_e;
  bit [1:0]   m_cause;
  bit         pin_pipe[$];
  bit         s_old;
  logic [CH-1:0] m_out;
  logic          m_rdy;

  initial begin
    m_assert = 1'b1;
    m_deb    = 1'b1;
    m_run    = 0;
    m_a      = 0;
    m_e      = 0;
    m_cause  = 2'b00;
    for (int i = 0; i < SYN; i++) pin_pipe.push_back(1'b1);
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (reset) begin
        pin_pipe.delete();
        for (int i = 0; i < SYN; i++) pin_pipe.push_back(1'b1);
        m_deb    = 1'b1;
        m_run    = 0;
        m_assert = 1'b1;
        m_a      = edge_cnt;
        m_cause  = 2'b00;
      end else begin
        s_old = pin_pipe[$];
        pin_pipe.push_front(rawReset);
        void'(pin_pipe.pop_back());
        if (m_assert) begin
          if ((edge_cnt - m_a >= HOLD) && !m_deb && !swResetReq) begin
            m_assert = 1'b0;
            m_e      = edge_cnt;
          end
        end else if (m_deb || swResetReq) begin
          m_assert = 1'b1;
          m_a      = edge_cnt;
          m_cause  = m_deb ? 2'b01 : 2'b10;
        end
        if (s_old != m_deb) begin
          m_run++;
          if (m_run == DEB) begin
            m_deb = !m_deb;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      for (int k = 0; k < CH; k++)
        m_out[k] = m_assert ? 1'b1 : (edge_cnt < m_e + SD * (k + 1));
      m_rdy = !m_assert && (edge_cnt >= m_e + SD * CH);
      exp_q.push_back({m_out, m_rdy, m_cause});
    end
  end

  // Monitor: one expected vector per edge, compared mid-cycle.
  logic [W-1:0] got;
  logic [W-1:0] want;

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        got  = {resetOut, ready, cause};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL scoreboard edge %0d: got out=%b rdy=%b cause=%b expected out=%b rdy=%b cause=%b",
                   edge_cnt, got[W-1:3], got[2], got[1:0], want[W-1:3], want[2], want[1:0]);
        end
      end
    end
  end

  // Driver helpers.
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic at_edge(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  task automatic expect_at(input int e, input string tag, input logic [CH-1:0] o,
                           input logic r, input logic [1:0] c);
    at_edge(e);
    chk({tag, "_out"}, 8'(o), 8'(o));
    chk({tag, "_out"}, 8'(resetOut), 8'(o));
    chk({tag, "_ready"}, 8'(ready), 8'(r));
    chk({tag, "_cause"}, 8'(cause), 8'(c));
  endtask

  int base, n, p, q, base2;
  int run_len, lvl_left;
  bit lvl;

  initial begin
    reset      = 1'b1;
    rawReset   = 1'b0;
    swResetReq = 1'b0;

    // Power-on sequence.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base  = edge_cnt;
    expect_at(base,      "por_reset", 4'hF, 1'b0, 2'b00);
    expect_at(base + 18, "por_hold",  4'hF, 1'b0, 2'b00);
    expect_at(base + 22, "por_pre0",  4'hF, 1'b0, 2'b00);
    expect_at(base + 23, "por_bit0",  4'hE, 1'b0, 2'b00);
    expect_at(base + 27, "por_bit1",  4'hC, 1'b0, 2'b00);
    expect_at(base + 31, "por_bit2",  4'h8, 1'b0, 2'b00);
    expect_at(base + 34, "por_pre3",  4'h8, 1'b0, 2'b00);
    expect_at(base + 35, "por_ready", 4'h0, 1'b1, 2'b00);

    // Software reset from RUN.
    at_edge(base + 40);
    swResetReq = 1'b1;
    n = edge_cnt;
    @(negedge clk);
    swResetReq = 1'b0;
    expect_at(n + 1,  "sw_assert", 4'hF, 1'b0, 2'b10);
    expect_at(n + 12, "sw_hold",   4'hF, 1'b0, 2'b10);
    expect_at(n + 13, "sw_bit0",   4'hE, 1'b0, 2'b10);
    expect_at(n + 24, "sw_pre",    4'h8, 1'b0, 2'b10);
    expect_at(n + 25, "sw_ready",  4'h0, 1'b1, 2'b10);

    // Glitch rejection: a 10-cycle pulse, then bouncing with short highs.
    at_edge(n + 30);
    rawReset = 1'b1;
    repeat (10) @(negedge clk);
    rawReset = 1'b0;
    run_len = 0;
    repeat (80) begin
      lvl = 1'($urandom_range(0, 1));
      if (run_len >= 12) lvl = 1'b0;
      rawReset = lvl;
      run_len = lvl ? run_len + 1 : 0;
      @(negedge clk);
    end
    rawReset = 1'b0;
    repeat (20) @(negedge clk);
    expect_at(edge_cnt, "glitch", 4'h0, 1'b1, 2'b10);

    // Pin reset held for 40 cycles.
    p = edge_cnt;
    rawReset = 1'b1;
    expect_at(p + 18, "pin_pre",    4'h0, 1'b1, 2'b10);
    expect_at(p + 19, "pin_assert", 4'hF, 1'b0, 2'b01);
    at_edge(p + 40);
    rawReset = 1'b0;
    expect_at(p + 58, "pin_hold",  4'hF, 1'b0, 2'b01);
    expect_at(p + 62, "pin_pre0",  4'hF, 1'b0, 2'b01);
    expect_at(p + 63, "pin_bit0",  4'hE, 1'b0, 2'b01);
    expect_at(p + 75, "pin_ready", 4'h0, 1'b1, 2'b01);

    // Re-entry during RELEASE with pin and software together.
    at_edge(p + 80);
    q = edge_cnt;
    swResetReq = 1'b1;
    rawReset   = 1'b1;
    @(negedge clk);
    swResetReq = 1'b0;
    expect_at(q + 1,  "re_sw",    4'hF, 1'b0, 2'b10);
    expect_at(q + 13, "re_bit0",  4'hE, 1'b0, 2'b10);
    expect_at(q + 18, "re_bit1",  4'hC, 1'b0, 2'b10);
    swResetReq = 1'b1;
    expect_at(q + 19, "re_both",  4'hF, 1'b0, 2'b01);
    at_edge(q + 25);
    rawReset = 1'b0;
    expect_at(q + 40, "re_ext",   4'hF, 1'b0, 2'b01);
    at_edge(q + 60);
    swResetReq = 1'b0;
    expect_at(q + 64, "re_pre0",  4'hF, 1'b0, 2'b01);
    expect_at(q + 65, "re_rel0",  4'hE, 1'b0, 2'b01);

    // Block reset in the middle of RELEASE.
    expect_at(q + 70, "mid_pre",  4'hC, 1'b0, 2'b01);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base2 = edge_cnt;
    expect_at(base2,      "mid_reset", 4'hF, 1'b0, 2'b00);
    expect_at(base2 + 18, "mid_hold",  4'hF, 1'b0, 2'b00);
    expect_at(base2 + 23, "mid_bit0",  4'hE, 1'b0, 2'b00);
    expect_at(base2 + 35, "mid_ready", 4'h0, 1'b1, 2'b00);

    // Random activity, checked by the scoreboard only.
    lvl_left = 0;
    lvl = 1'b0;
    repeat (800) begin
      if (lvl_left == 0) begin
        lvl      = 1'($urandom_range(0, 1));
        lvl_left = $urandom_range(1, 30);
      end
      rawReset   = lvl;
      lvl_left--;
      swResetReq = ($urandom_range(0, 24) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rawReset   = 1'b0;
    swResetReq = 1'b0;
    reset      = 1'b0;
    repeat (60) @(negedge clk);
    expect_at(edge_cnt, "final", 4'h0, 1'b1, cause);
    chk("queue_drain", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
